// File: rtl/bsg_cache_nb_pkg.sv
// rtl/bsg_cache_nb_pkg.sv - shared types and width helpers for the non-blocking cache DMA path
package bsg_cache_nb_pkg;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int block_offset_width(input int block_size_in_words, input int word_width);
        return $clog2(block_size_in_words * word_width / 8);
    endfunction

    // Packet layout, MSB first: {write_not_read, addr, mask, mshr_id}
    function automatic int dma_pkt_width(input int addr_width, input int block_size_in_words,
                                         input int mshr_els);
        return 1 + addr_width + block_size_in_words + safe_clog2(mshr_els);
    endfunction

    typedef struct packed {
        logic valid;
        logic issued;
        logic data_done;
    } wq_entry_state_s;

endpackage

// File: rtl/bsg_cache_nb_dma_sched_wq.sv
// rtl/bsg_cache_nb_dma_sched_wq.sv - evict write queue with block-address CAM, issue and retire tracking
module bsg_cache_nb_dma_sched_wq
    import bsg_cache_nb_pkg::*;
#(
    parameter int pkt_width_p = 43,
    parameter int els_p       = 4,
    parameter int blk_lsb_p   = 15,
    parameter int blk_width_p = 27,
    localparam int ptr_width_lp   = safe_clog2(els_p),
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enq_v,
    input  logic [pkt_width_p-1:0]    i_enq_pkt,
    input  logic                      i_issue,
    input  logic                      i_data_done,
    input  logic [blk_width_p-1:0]    i_cam_blk,
    output logic                      o_cam_hit,
    output logic                      o_head_v,
    output logic [pkt_width_p-1:0]    o_head_pkt,
    output logic                      o_full,
    output logic [count_width_lp-1:0] o_count
);

    localparam logic [ptr_width_lp-1:0]   last_ptr_lp   = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    wq_entry_state_s [els_p-1:0] r_state;
    logic [pkt_width_p-1:0]      r_pkt [els_p];
    logic [ptr_width_lp-1:0]     r_wr_ptr;
    logic [ptr_width_lp-1:0]     r_rd_ptr;
    logic [ptr_width_lp-1:0]     r_issue_ptr;
    logic [ptr_width_lp-1:0]     r_data_ptr;
    logic [count_width_lp-1:0]   r_count;

    logic w_enq;
    logic w_issue;
    logic w_data_fire;
    logic w_rd_issued;
    logic w_rd_done;
    logic w_retire;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    assign o_full     = (r_count == full_count_lp);
    assign o_count    = r_count;
    assign o_head_v   = r_state[r_issue_ptr].valid & ~r_state[r_issue_ptr].issued;
    assign o_head_pkt = r_pkt[r_issue_ptr];

    assign w_enq       = i_enq_v & ~o_full;
    assign w_issue     = i_issue & o_head_v;
    // Evict data may arrive before its packet is issued, so it tracks its own pointer
    assign w_data_fire = i_data_done & r_state[r_data_ptr].valid & ~r_state[r_data_ptr].data_done;

    // Flags set on this edge count toward retiring the oldest entry on the same edge
    assign w_rd_issued = r_state[r_rd_ptr].issued    | (w_issue     & (r_issue_ptr == r_rd_ptr));
    assign w_rd_done   = r_state[r_rd_ptr].data_done | (w_data_fire & (r_data_ptr  == r_rd_ptr));
    assign w_retire    = r_state[r_rd_ptr].valid & w_rd_issued & w_rd_done;

    always_comb begin
        o_cam_hit = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            if (r_state[i].valid && (r_pkt[i][blk_lsb_p +: blk_width_p] == i_cam_blk)) begin
                o_cam_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_issue_ptr <= '0;
            r_data_ptr  <= '0;
            r_count     <= '0;
        end else begin
            if (w_enq) begin
                r_state[r_wr_ptr] <= '{valid: 1'b1, issued: 1'b0, data_done: 1'b0};
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_issue) begin
                r_state[r_issue_ptr].issued <= 1'b1;
                r_issue_ptr                 <= ptr_inc(r_issue_ptr);
            end
            if (w_data_fire) begin
                r_state[r_data_ptr].data_done <= 1'b1;
                r_data_ptr                    <= ptr_inc(r_data_ptr);
            end
            if (w_retire) begin
                r_state[r_rd_ptr] <= '0;
                r_rd_ptr          <= ptr_inc(r_rd_ptr);
            end
            case ({w_enq, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_pkt[r_wr_ptr] <= i_enq_pkt;
        end
    end

endmodule

// File: rtl/bsg_cache_nb_dma_scheduler.sv
// rtl/bsg_cache_nb_dma_scheduler.sv - read-bypass DMA scheduler with write buffering and RAW blocking
module bsg_cache_nb_dma_scheduler
    import bsg_cache_nb_pkg::*;
#(
    parameter int addr_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int word_width_p          = 32,
    parameter int dma_data_width_p      = 64,
    parameter int mshr_els_p            = 4,
    parameter int starve_limit_p        = 16,
    localparam int block_size_in_bursts_lp = block_size_in_words_p * word_width_p / dma_data_width_p,
    localparam int dma_pkt_width_lp        = dma_pkt_width(addr_width_p, block_size_in_words_p, mshr_els_p),
    localparam int wq_count_width_lp       = $clog2(mshr_els_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [dma_pkt_width_lp-1:0]  dma_pkt_i,
    input  logic                         dma_pkt_v_i,
    output logic                         dma_pkt_yumi_o,
    output logic [dma_pkt_width_lp-1:0]  mem_pkt_o,
    output logic                         mem_pkt_v_o,
    input  logic                         mem_pkt_yumi_i,
    input  logic                         evict_data_v_i,
    input  logic                         evict_data_yumi_i,
    output logic [wq_count_width_lp-1:0] wq_count_o
);

    localparam int id_width_lp        = safe_clog2(mshr_els_p);
    localparam int block_offset_lp    = block_offset_width(block_size_in_words_p, word_width_p);
    localparam int blk_lsb_lp         = id_width_lp + block_size_in_words_p + block_offset_lp;
    localparam int blk_width_lp       = addr_width_p - block_offset_lp;
    localparam int burst_cnt_width_lp = safe_clog2(block_size_in_bursts_lp);
    localparam int age_width_lp       = $clog2(starve_limit_p + 1);
    localparam logic [burst_cnt_width_lp-1:0] last_burst_lp = burst_cnt_width_lp'(block_size_in_bursts_lp - 1);
    localparam logic [age_width_lp-1:0]       starve_lp     = age_width_lp'(starve_limit_p);

    logic [age_width_lp-1:0]       r_age;
    logic [burst_cnt_width_lp-1:0] r_burst_cnt;

    logic                        w_in_wnr;
    logic [blk_width_lp-1:0]     w_in_blk;
    logic                        w_is_rd;
    logic                        w_cam_hit;
    logic                        w_hz;
    logic                        w_head_v;
    logic [dma_pkt_width_lp-1:0] w_head_pkt;
    logic                        w_full;
    logic                        w_force_wr;
    logic                        w_rd_ok;
    logic                        w_wr_issue;
    logic                        w_enq;
    logic                        w_beat;
    logic                        w_data_done;

    assign w_in_wnr = dma_pkt_i[dma_pkt_width_lp-1];
    assign w_in_blk = dma_pkt_i[blk_lsb_lp +: blk_width_lp];
    assign w_is_rd  = dma_pkt_v_i & ~w_in_wnr;
    assign w_hz     = w_is_rd & w_cam_hit;

    // Reads bypass queued writes unless the head has starved or the queue is full
    assign w_force_wr = w_head_v & ((r_age >= starve_lp) | w_full);
    assign w_rd_ok    = w_is_rd & ~w_hz & ~w_force_wr;
    assign w_wr_issue = ~w_rd_ok & w_head_v & mem_pkt_yumi_i;
    assign w_enq      = dma_pkt_v_i & w_in_wnr & ~w_full;

    assign mem_pkt_v_o    = w_rd_ok | w_head_v;
    assign mem_pkt_o      = w_rd_ok ? dma_pkt_i : w_head_pkt;
    assign dma_pkt_yumi_o = w_enq | (w_rd_ok & mem_pkt_yumi_i);

    assign w_beat      = evict_data_v_i & evict_data_yumi_i;
    assign w_data_done = w_beat & (r_burst_cnt == last_burst_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_age       <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_wr_issue) begin
                r_age <= '0;
            end else if (w_head_v & w_rd_ok & mem_pkt_yumi_i & (r_age < starve_lp)) begin
                r_age <= r_age + 1'b1;
            end
            if (w_beat) begin
                r_burst_cnt <= (r_burst_cnt == last_burst_lp) ? '0 : r_burst_cnt + 1'b1;
            end
        end
    end

    bsg_cache_nb_dma_sched_wq #(
        .pkt_width_p (dma_pkt_width_lp),
        .els_p       (mshr_els_p),
        .blk_lsb_p   (blk_lsb_lp),
        .blk_width_p (blk_width_lp)
    ) u_wq (
        .i_clk       (clk_i),
        .i_reset     (reset_i),
        .i_enq_v     (w_enq),
        .i_enq_pkt   (dma_pkt_i),
        .i_issue     (w_wr_issue),
        .i_data_done (w_data_done),
        .i_cam_blk   (w_in_blk),
        .o_cam_hit   (w_cam_hit),
        .o_head_v    (w_head_v),
        .o_head_pkt  (w_head_pkt),
        .o_full      (w_full),
        .o_count     (wq_count_o)
    );

endmodule

// File: tb/tb_bsg_cache_nb_dma_scheduler.sv
// tb/tb_bsg_cache_nb_dma_scheduler.sv - scoreboard bench for the DMA scheduler
module tb_bsg_cache_nb_dma_scheduler;

    localparam int PW = 43;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [PW-1:0] dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_yumi_o;
    logic [PW-1:0] mem_pkt_o;
    logic          mem_pkt_v_o;
    logic          mem_pkt_yumi_i;
    logic          evict_data_v_i;
    logic          evict_data_yumi_i;
    logic [2:0]    wq_count_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    bsg_cache_nb_dma_scheduler dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .dma_pkt_i         (dma_pkt_i),
        .dma_pkt_v_i       (dma_pkt_v_i),
        .dma_pkt_yumi_o    (dma_pkt_yumi_o),
        .mem_pkt_o         (mem_pkt_o),
        .mem_pkt_v_o       (mem_pkt_v_o),
        .mem_pkt_yumi_i    (mem_pkt_yumi_i),
        .evict_data_v_i    (evict_data_v_i),
        .evict_data_yumi_i (evict_data_yumi_i),
        .wq_count_o        (wq_count_o)
    );

    function automatic logic [PW-1:0] mk(input logic wnr, input logic [31:0] addr,
                                         input logic [7:0] mask, input logic [1:0] id);
        return {wnr, addr, mask, id};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bursts(input int n);
        evict_data_v_i    = 1'b1;
        evict_data_yumi_i = 1'b1;
        repeat (n) tick();
        evict_data_v_i    = 1'b0;
        evict_data_yumi_i = 1'b0;
    endtask

    // Monitor: every memory-side handshake must match the next expected packet
    always @(negedge clk) begin
        if (!reset_i && mem_pkt_v_o && mem_pkt_yumi_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_pkt_unexpected: got 0x%0h expected none", mem_pkt_o);
            end else begin
                chk("mem_pkt", mem_pkt_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [PW-1:0] p;
        logic [PW-1:0] r;
        logic [PW-1:0] w;
        logic [PW-1:0] wf[4];

        reset_i = 1'b1;
        dma_pkt_i = '0;
        dma_pkt_v_i = 1'b0;
        mem_pkt_yumi_i = 1'b0;
        evict_data_v_i = 1'b0;
        evict_data_yumi_i = 1'b0;
        tick();
        tick();
        chk("reset_count", wq_count_o, 0);
        chk("reset_mem_v", mem_pkt_v_o, 0);
        chk("reset_yumi", dma_pkt_yumi_o, 0);
        reset_i = 1'b0;

        // Read with empty queue: cut-through
        p = mk(1'b0, 32'h100, 8'hFF, 2'd1);
        dma_pkt_i = p; dma_pkt_v_i = 1'b1; mem_pkt_yumi_i = 1'b1;
        exp_q.push_back(p);
        #1;
        chk("rd_yumi", dma_pkt_yumi_o, 1);
        chk("rd_cut_through", mem_pkt_o, p);
        tick();
        dma_pkt_v_i = 1'b0; mem_pkt_yumi_i = 1'b0;
        #1;
        chk("rd_count", wq_count_o, 0);

        // Write then four bursts
        p = mk(1'b1, 32'h200, 8'h0F, 2'd2);
        dma_pkt_i = p; dma_pkt_v_i = 1'b1;
        #1;
        chk("wr_yumi", dma_pkt_yumi_o, 1);
        tick();
        dma_pkt_v_i = 1'b0;
        #1;
        chk("wr_count", wq_count_o, 1);
        chk("wr_head_v", mem_pkt_v_o, 1);
        exp_q.push_back(p);
        mem_pkt_yumi_i = 1'b1;
        tick();
        mem_pkt_yumi_i = 1'b0;
        bursts(3);
        #1;
        chk("wr_count_3_bursts", wq_count_o, 1);
        bursts(1);
        #1;
        chk("wr_count_retired", wq_count_o, 0);

        // RAW hazard
        w = mk(1'b1, 32'h400, 8'hF0, 2'd0);
        dma_pkt_i = w; dma_pkt_v_i = 1'b1;
        tick();
        r = mk(1'b0, 32'h404, 8'h01, 2'd3);
        dma_pkt_i = r;
        #1;
        chk("raw_rd_stall", dma_pkt_yumi_o, 0);
        chk("raw_head_pkt", mem_pkt_o, w);
        exp_q.push_back(w);
        mem_pkt_yumi_i = 1'b1;
        tick();
        #1;
        chk("raw_stall_after_issue", dma_pkt_yumi_o, 0);
        chk("raw_mem_v_idle", mem_pkt_v_o, 0);
        bursts(3);
        #1;
        chk("raw_stall_3_bursts", dma_pkt_yumi_o, 0);
        exp_q.push_back(r);
        bursts(1);
        #1;
        chk("raw_rd_grant", dma_pkt_yumi_o, 1);
        tick();
        dma_pkt_v_i = 1'b0; mem_pkt_yumi_i = 1'b0;

        // Starvation: 16 bypassing reads, then the write is forced
        w = mk(1'b1, 32'h800, 8'hAA, 2'd1);
        dma_pkt_i = w; dma_pkt_v_i = 1'b1; mem_pkt_yumi_i = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            r = mk(1'b0, 32'h1000 + 32'(32 * i), 8'(i), 2'(i));
            dma_pkt_i = r;
            exp_q.push_back(r);
            #1;
            chk("starve_rd_bypass", dma_pkt_yumi_o, 1);
            tick();
        end
        r = mk(1'b0, 32'h3000, 8'h5A, 2'd2);
        dma_pkt_i = r;
        #1;
        chk("starve_rd_blocked", dma_pkt_yumi_o, 0);
        chk("starve_forced_pkt", mem_pkt_o, w);
        exp_q.push_back(w);
        tick();
        exp_q.push_back(r);
        #1;
        chk("starve_age_cleared", dma_pkt_yumi_o, 1);
        tick();
        dma_pkt_v_i = 1'b0; mem_pkt_yumi_i = 1'b0;
        bursts(4);
        #1;
        chk("starve_retired", wq_count_o, 0);

        // Full queue with memory stalled
        for (int i = 0; i < 4; i++) begin
            wf[i] = mk(1'b1, 32'h5000 + 32'(32 * i), 8'h11 + 8'(i), 2'(i));
            dma_pkt_i = wf[i]; dma_pkt_v_i = 1'b1;
            #1;
            chk("full_fill_yumi", dma_pkt_yumi_o, 1);
            tick();
        end
        r = mk(1'b0, 32'h7000, 8'hC3, 2'd0);
        dma_pkt_i = r;
        #1;
        chk("full_count", wq_count_o, 4);
        chk("full_rd_blocked", dma_pkt_yumi_o, 0);
        chk("full_head_pkt", mem_pkt_o, wf[0]);
        w = mk(1'b1, 32'h6000, 8'h77, 2'd3);
        dma_pkt_i = w;
        #1;
        chk("full_wr_blocked", dma_pkt_yumi_o, 0);
        exp_q.push_back(wf[0]);
        mem_pkt_yumi_i = 1'b1;
        tick();
        mem_pkt_yumi_i = 1'b0;
        bursts(4);
        #1;
        chk("full_after_retire_count", wq_count_o, 3);
        chk("full_accept_next", dma_pkt_yumi_o, 1);
        tick();
        dma_pkt_v_i = 1'b0;
        #1;
        chk("full_refill_count", wq_count_o, 4);

        // Drain two, then reset with 2 entries and burst count 2
        exp_q.push_back(wf[1]);
        exp_q.push_back(wf[2]);
        mem_pkt_yumi_i = 1'b1;
        tick();
        tick();
        mem_pkt_yumi_i = 1'b0;
        bursts(8);
        #1;
        chk("pre_reset_count", wq_count_o, 2);
        bursts(2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("midreset_count", wq_count_o, 0);
        chk("midreset_mem_v", mem_pkt_v_o, 0);
        chk("midreset_yumi", dma_pkt_yumi_o, 0);

        w = mk(1'b1, 32'h9000, 8'h3C, 2'd1);
        dma_pkt_i = w; dma_pkt_v_i = 1'b1;
        #1;
        chk("post_reset_wr_yumi", dma_pkt_yumi_o, 1);
        tick();
        dma_pkt_v_i = 1'b0;
        exp_q.push_back(w);
        mem_pkt_yumi_i = 1'b1;
        tick();
        mem_pkt_yumi_i = 1'b0;
        bursts(2);
        #1;
        chk("post_reset_burst_cnt_clear", wq_count_o, 1);
        bursts(2);
        #1;
        chk("post_reset_retired", wq_count_o, 0);

        tick();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
